mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the RV32I46F data-memory bus, downstream of the core.
- Consumes store traffic from the core's load/store path.
- Buffers bytes in a small FIFO and serialises them 8N1 on a single tx pin.
- Lets core test programs emit visible characters during clk/reset-driven simulation.

---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 146 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding
// for the memory-mapped UART transmitter.
package uart_tx_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_CTRL   = 4'h8;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; a push while full is still
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointers are exactly AW bits wide, so plain increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: register decode, TX FIFO and 8N1 serialiser with a
// registered tx pin and registered empty interrupt.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mmio_we,
    input  logic        mmio_re,
    input  logic [3:0]  mmio_addr,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    output logic        tx,
    output logic        irq_empty
);

    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;
    logic        ovf_q, ovf_d;

    logic          push_req, push_ok, pop;
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count, cnt_next;
    logic          unused_wdata;

    assign unused_wdata = ^mmio_wdata[31:8];
    assign push_req     = mmio_we && (mmio_addr == UART_TXDATA);
    assign push_ok      = push_req && (!fifo_full || pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push_req),
        .wdata_i (mmio_wdata[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = RELOAD;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    baud_d  = RELOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = RELOAD;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_q == '0) state_d = ST_IDLE;
                else              baud_d  = baud_q - 16'd1;
            end
        endcase

        // tx and irq are registered, so they are derived from next-state values.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[bit_d];
            default:  tx_d = 1'b1;
        endcase

        cnt_next = fifo_count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};
        irq_d    = (cnt_next == '0) && (state_d == ST_IDLE);

        ovf_d = ovf_q;
        if (push_req && !push_ok)
            ovf_d = 1'b1;
        else if (mmio_we && (mmio_addr == UART_CTRL) && mmio_wdata[0])
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        if (mmio_re && (mmio_addr == UART_STATUS)) begin
            mmio_rdata[STAT_FULL]  = fifo_full;
            mmio_rdata[STAT_EMPTY] = fifo_empty;
            mmio_rdata[STAT_BUSY]  = (state_q != ST_IDLE);
            mmio_rdata[STAT_OVF]   = ovf_q;
        end
    end

    assign tx        = tx_q;
    assign irq_empty = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and random store traffic checked every
// cycle against a queue-and-frame-timing reference model.
module tb_mmio_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mmio_we, mmio_re;
    logic [3:0]  mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        tx, irq_empty;

    int checks   = 0;
    int failures = 0;

    // Reference model: queued bytes, plus the edge at which the current frame began.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    bit         m_have;
    bit         m_ovf;
    int         m_last;
    int         m_edge;

    mmio_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mmio_we    (mmio_we),
        .mmio_re    (mmio_re),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .tx         (tx),
        .irq_empty  (irq_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, m_edge);
        end
    endtask

    function automatic bit busy_at(input int e);
        return m_have && (e >= m_last) && (e < m_last + 10 * C);
    endfunction

    // Frame = 10 slots of C cycles: start, 8 data bits LSB first, stop.
    function automatic logic exp_tx();
        int k, slot;
        if (!busy_at(m_edge)) return 1'b1;
        k    = m_edge - m_last;
        slot = k / C;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s    = '0;
        s[0] = (m_q.size() == D);
        s[1] = (m_q.size() == 0);
        s[2] = busy_at(m_edge);
        s[3] = m_ovf;
        return s;
    endfunction

    task automatic model(input logic we, input logic [3:0] a, input logic [31:0] d, input logic rs);
        bit pop;
        m_edge++;
        if (rs) begin
            m_q.delete();
            m_have = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        pop = !busy_at(m_edge - 1) && (m_q.size() > 0);
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_last = m_edge;
            m_have = 1'b1;
        end
        if (we && a == 4'h0) begin
            if (m_q.size() < D) m_q.push_back(d[7:0]);
            else                m_ovf = 1'b1;
        end
        if (we && a == 4'h8 && d[0]) m_ovf = 1'b0;
    endtask

    // Called at a falling edge: probe STATUS, drive one cycle, then check outputs.
    task automatic step(input logic we, input logic [3:0] a, input logic [31:0] d, input logic rs);
        mmio_we   = 1'b0;
        mmio_re   = 1'b1;
        mmio_addr = 4'h4;
        #1;
        chk("status", mmio_rdata, exp_status());
        mmio_re = 1'b0;
        #1;
        chk("rdata_re0", mmio_rdata, 32'h0);
        mmio_we    = we;
        mmio_addr  = a;
        mmio_wdata = d;
        reset      = rs;
        @(posedge clk);
        model(we, a, d, rs);
        @(negedge clk);
        chk("tx", {31'b0, tx}, {31'b0, exp_tx()});
        chk("irq_empty", {31'b0, irq_empty}, {31'b0, (m_q.size() == 0) && !busy_at(m_edge)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_q.size() != 0 || busy_at(m_edge)) && n < 2000) begin
            idle(1);
            n++;
        end
        idle(3);
    endtask

    task automatic probe_zero(input logic [3:0] a);
        mmio_we   = 1'b0;
        mmio_re   = 1'b1;
        mmio_addr = a;
        #1;
        chk("rdata_unmapped", mmio_rdata, 32'h0);
        mmio_re = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int r;
        reset      = 1'b1;
        mmio_we    = 1'b0;
        mmio_re    = 1'b0;
        mmio_addr  = 4'h0;
        mmio_wdata = 32'h0;
        m_have     = 1'b0;
        m_ovf      = 1'b0;
        m_last     = 0;
        m_edge     = 0;
        m_cur      = 8'h00;
        @(negedge clk);

        // Reset state.
        step(1'b0, 4'h0, 32'h0, 1'b1);
        step(1'b0, 4'h0, 32'h0, 1'b1);
        idle(2);

        // Single frame.
        wr(4'h0, 32'h0000_0055);
        drain();

        // Back-to-back frames.
        wr(4'h0, 32'h41);
        wr(4'h0, 32'h42);
        wr(4'h0, 32'h43);
        wr(4'h0, 32'h44);
        drain();

        // Overflow on six consecutive writes, then CTRL clear.
        for (int i = 0; i < 6; i++) wr(4'h0, $urandom);
        idle(3);
        wr(4'h8, 32'hFFFF_FFFE);
        idle(1);
        wr(4'h8, 32'h0000_0001);
        drain();

        // Push while full on the very cycle of a pop.
        wr(4'h0, $urandom);
        for (int i = 0; i < 4; i++) wr(4'h0, $urandom);
        while (m_edge < m_last + 10 * C) idle(1);
        wr(4'h0, $urandom);
        idle(2);
        drain();

        // Reset in the middle of data bit 3.
        wr(4'h0, $urandom);
        wr(4'h0, $urandom);
        wr(4'h0, $urandom);
        r = $urandom_range(C - 1, 0);
        while (m_edge < m_last + 4 * C + 1 + r) idle(1);
        step(1'b0, 4'h0, 32'h0, 1'b1);
        idle(45);
        wr(4'h0, 32'h0F);
        drain();

        // Decode: unmapped reads and STATUS writes.
        probe_zero(4'h0);
        probe_zero(4'hC);
        probe_zero(4'h8);
        wr(4'h4, 32'hFFFF_FFFF);
        wr(4'hC, 32'hFFFF_FFFF);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(9, 0);
            b = 8'($urandom);
            if (r < 3)       wr(4'h0, {24'($urandom), b});
            else if (r == 3) wr(4'h8, $urandom);
            else if (r == 4) wr(4'(4 * $urandom_range(3, 0)), $urandom);
            else             idle(1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
